// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: FSM encoding and width helper shared by the sequential multiplier
package seq_mult_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/product valid-ready bundle for the sequential multiplier
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// seq_mult_datapath: magnitude shift-add accumulator with sign-conditioned product register
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_load,
    input  logic                         i_step,
    input  logic                         i_finish,
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    output logic [prod_w(WIDTH)-1:0]     o_product
);
    localparam int PW = prod_w(WIDTH);
    logic [PW-1:0]    r_acc, r_mcand, r_product, w_partial;
    logic [WIDTH-1:0] r_mult, w_abs_a, w_abs_b;
    logic             r_neg;
    // the most-negative operand negates to 2^(WIDTH-1), which still fits unsigned
    assign w_abs_a   = (SIGNED && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b   = (SIGNED && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_partial = r_mult[0] ? r_mcand : '0;
    assign o_product = r_product;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mult    <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
            r_mult  <= w_abs_b;
            r_neg   <= SIGNED && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end else if (i_step) begin
            r_acc   <= r_acc + w_partial;
            r_mcand <= r_mcand << 1;
            r_mult  <= r_mult >> 1;
        end else if (i_finish) begin
            r_product <= r_neg ? -r_acc : r_acc;
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative WIDTH x WIDTH multiplier, FSM and handshakes around the datapath
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input logic       clk,
    input logic       reset_n,
    seq_mult_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept, w_step, w_finish;
    // WIDTH add cycles, then one cycle to register the sign-conditioned product
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_finish = (r_state == S_CALC) && (r_cnt == CNT_W'(WIDTH));
    assign w_step   = (r_state == S_CALC) && !w_finish;
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_accept ? S_CALC :
                       w_finish ? S_DONE :
                       ((r_state == S_DONE) && bus.out_ready) ? S_IDLE : r_state;
            r_cnt   <= w_accept ? '0 : w_step ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end
    seq_mult_datapath #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_finish  (w_finish),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_product (bus.product)
    );
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed W=4 vectors on unsigned/signed twins plus random ops per width/mode
module tb_seq_multiplier;
    logic       clk = 1'b0;
    logic       d_rst_n, rr_n, d_valid, d_rdy;
    logic [3:0] d_a, d_b;
    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    seq_mult_if #(.WIDTH(4)) ui();
    seq_mult_if #(.WIDTH(4)) si();
    assign ui.in_valid  = d_valid;
    assign ui.a         = d_a;
    assign ui.b         = d_b;
    assign ui.out_ready = d_rdy;
    assign si.in_valid  = d_valid;
    assign si.a         = d_a;
    assign si.b         = d_b;
    assign si.out_ready = d_rdy;
    seq_multiplier #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (.clk(clk), .reset_n(d_rst_n), .bus(ui.slave));
    seq_multiplier #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (.clk(clk), .reset_n(d_rst_n), .bus(si.slave));
    for (genvar g = 0; g < 6; g++) begin : g_rnd
        localparam int W = (g < 2) ? 2 : (g < 4) ? 4 : 8;
        localparam bit S = (g % 2) == 1;
        seq_mult_if #(.WIDTH(W)) rif();
        seq_multiplier #(.WIDTH(W), .SIGNED(S)) u_dut (.clk(clk), .reset_n(rr_n), .bus(rif.slave));
        initial begin
            logic [W-1:0] va, vb;
            logic [63:0]  ex;
            longint       sa, sb;
            int           n;
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b0;
            rif.a         = '0;
            rif.b         = '0;
            @(posedge rr_n);
            @(posedge clk);
            #1;
            for (int i = 0; i < 1000; i++) begin
                va = W'($urandom);
                vb = W'($urandom);
                sa = (S && va[W-1]) ? longint'(va) - (longint'(1) << W) : longint'(va);
                sb = (S && vb[W-1]) ? longint'(vb) - (longint'(1) << W) : longint'(vb);
                ex = 64'(sa * sb) & ((64'd1 << (2 * W)) - 64'd1);
                repeat ($urandom_range(0, 3)) begin
                    rif.out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                rif.a        = va;
                rif.b        = vb;
                rif.in_valid = 1'b1;
                @(posedge clk);
                #1;
                rif.in_valid = 1'b0;
                rif.a        = W'($urandom);
                rif.b        = W'($urandom);
                n = 0;
                while (n < 64) begin
                    rif.out_ready = 1'($urandom);
                    if (rif.out_valid && rif.out_ready) break;
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk($sformatf("rnd_w%0d_s%0d_to", W, S), 64'(n < 64), 64'd1);
                chk($sformatf("rnd_w%0d_s%0d_%0h_%0h", W, S, va, vb), 64'(rif.product), ex);
                @(posedge clk);
                #1;
                rif.out_ready = 1'b0;
            end
            done_cnt++;
        end
    end
    task automatic dop(input logic [3:0] a, input logic [3:0] b, input logic [7:0] eu,
                       input logic [7:0] es, input string tag);
        int n;
        d_a     = a;
        d_b     = b;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_a     = ~a;
        d_b     = ~b;
        n = 0;
        while (!ui.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd5);
        chk({tag, "_u"}, 64'(ui.product), 64'(eu));
        chk({tag, "_s"}, 64'(si.product), 64'(es));
        chk({tag, "_flags"}, 64'({ui.in_ready, ui.busy, si.out_valid}), 64'(3'b011));
        d_rdy = 1'b1;
        @(posedge clk);
        #1;
        d_rdy = 1'b0;
        chk({tag, "_idle"}, 64'({ui.in_ready, ui.out_valid, si.in_ready, si.busy}), 64'(4'b1010));
    endtask
    initial begin
        d_rst_n = 1'b0;
        rr_n    = 1'b0;
        d_valid = 1'b0;
        d_rdy   = 1'b0;
        d_a     = '0;
        d_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod", 64'({ui.product, si.product}), 64'd0);
        chk("rst_flags", 64'({ui.in_ready, ui.out_valid, ui.busy, si.in_ready, si.out_valid, si.busy}),
            64'(6'b100100));
        d_rst_n = 1'b1;
        rr_n    = 1'b1;
        @(posedge clk);
        #1;
        dop(4'd3,  4'd2,  8'd6,   8'd6,   "3x2");
        dop(4'd15, 4'd15, 8'd225, 8'd1,   "15x15");
        dop(4'd0,  4'd13, 8'd0,   8'd0,   "0x13");
        dop(4'd8,  4'd8,  8'h40,  8'h40,  "m8xm8");
        dop(4'd13, 4'd5,  8'h41,  8'hF1,  "m3x5");
        dop(4'd7,  4'd15, 8'h69,  8'hF9,  "7xm1");
        // backpressure: product held while out_ready low, in_valid pulse ignored
        d_a     = 4'd3;
        d_b     = 4'd2;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            d_valid = (i == 4);
            d_a     = 4'd15;
            d_b     = 4'd15;
            chk($sformatf("bp_%0d", i), 64'({ui.out_valid, ui.in_ready, ui.product, si.product}),
                64'({1'b1, 1'b0, 8'd6, 8'd6}));
            @(posedge clk);
            #1;
        end
        d_valid = 1'b0;
        d_rdy   = 1'b1;
        @(posedge clk);
        #1;
        d_rdy = 1'b0;
        chk("bp_rel", 64'({ui.in_ready, ui.out_valid, ui.busy}), 64'(3'b100));
        @(posedge clk);
        #1;
        chk("bp_ign", 64'({ui.busy, si.busy}), 64'd0);
        // asynchronous reset in the middle of CALC
        d_a     = 4'd5;
        d_b     = 4'd3;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", 64'(ui.busy), 64'd1);
        d_rst_n = 1'b0;
        #1;
        chk("mid_rst", 64'({ui.out_valid, ui.busy, ui.product, si.product}), 64'd0);
        @(posedge clk);
        #2;
        d_rst_n = 1'b1;
        #1;
        chk("mid_rel", 64'({ui.in_ready, si.in_ready, ui.out_valid}), 64'(3'b110));
        @(posedge clk);
        #1;
        dop(4'd7, 4'd15, 8'h69, 8'hF9, "post_rst");
        fork
            wait (done_cnt == 6);
            repeat (60000) @(posedge clk);
        join_any
        disable fork;
        chk("rnd_done", 64'(done_cnt), 64'd6);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
